descriptor_packer: RTL

DESCRIPTOR_PACKER -- requirements
Module: descriptor_packer

---
 rtl/sift_desc_pkg.sv | 14 +
 rtl/bin_saturate.sv | 18 +
 rtl/descriptor_packer.sv | 118 +++++++++++
 3 files changed

// File: rtl/sift_desc_pkg.sv
// Shared sizing and FSM encoding for the SIFT descriptor packing path.
package sift_desc_pkg;

    localparam int BIN_COUNT = 128;
    localparam int BIN_BITS  = 10;
    localparam int OUT_BITS  = 8;
    localparam int WORD_BITS = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } pack_state_t;

endpackage

// File: rtl/bin_saturate.sv
// Clamps one normalized descriptor bin to the packed bin width.
module bin_saturate #(
    parameter int IN_BITS  = sift_desc_pkg::BIN_BITS,
    parameter int OUT_BITS = sift_desc_pkg::OUT_BITS
) (
    input  logic [IN_BITS-1:0]  ibin,
    output logic [OUT_BITS-1:0] obin
);

    // Any set bit above the output width means the value exceeds the max.
    always_comb begin
        if (|ibin[IN_BITS-1:OUT_BITS])
            obin = '1;
        else
            obin = ibin[OUT_BITS-1:0];
    end

endmodule

// File: rtl/descriptor_packer.sv
// Saturates a 128-bin descriptor, buffers up to two, and streams each one
// out as 32 packed words with a valid/ready handshake.
module descriptor_packer #(
    parameter int BIN_COUNT = sift_desc_pkg::BIN_COUNT,
    parameter int BIN_BITS  = sift_desc_pkg::BIN_BITS,
    parameter int OUT_BITS  = sift_desc_pkg::OUT_BITS,
    parameter int WORD_BITS = sift_desc_pkg::WORD_BITS
) (
    input  logic                          iclk,
    input  logic                          ireset,
    input  logic                          idval,
    input  logic [BIN_COUNT*BIN_BITS-1:0] idescriptor,
    input  logic                          iready,
    output logic                          owvalid,
    output logic [WORD_BITS-1:0]          owdata,
    output logic                          owlast,
    output logic                          ooverflow,
    output logic [15:0]                   ocount,
    output logic                          obusy
);

    import sift_desc_pkg::*;

    localparam int DESC_BITS = BIN_COUNT * OUT_BITS;
    localparam int WORDS     = DESC_BITS / WORD_BITS;
    localparam int IDX_W     = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef logic [WORDS-1:0][WORD_BITS-1:0] desc_words_t;

    desc_words_t       sat_desc;
    desc_words_t       slot [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;
    logic [1:0]        occ_nxt;
    logic [IDX_W-1:0]  word_idx;
    pack_state_t       state;
    pack_state_t       state_nxt;
    logic              xfer;
    logic              final_xfer;
    logic              capture;
    logic              drop;

    for (genvar k = 0; k < BIN_COUNT; k++) begin : g_bin
        bin_saturate #(
            .IN_BITS  (BIN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_sat (
            .ibin (idescriptor[k*BIN_BITS +: BIN_BITS]),
            .obin (sat_desc[k*OUT_BITS/WORD_BITS][(k*OUT_BITS)%WORD_BITS +: OUT_BITS])
        );
    end

    // A full buffer can still accept when the head descriptor leaves this cycle.
    assign xfer       = owvalid & iready;
    assign final_xfer = xfer & owlast;
    assign capture    = idval & ((occ != 2'd2) | final_xfer);
    assign drop       = idval & ~capture;
    assign occ_nxt    = occ + {1'b0, capture} - {1'b0, final_xfer};
    assign obusy      = (occ != 2'd0);

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            // NOTE: the slot storage is reset too, so a discarded descriptor never resurfaces after reset.
            slot[0]   <= '0;
            slot[1]   <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
            word_idx  <= '0;
            ooverflow <= 1'b0;
            ocount    <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (capture) begin
                slot[wr_ptr] <= sat_desc;
                wr_ptr       <= ~wr_ptr;
            end
            if (xfer)
                word_idx <= final_xfer ? '0 : word_idx + IDX_W'(1);
            if (final_xfer) begin
                rd_ptr <= ~rd_ptr;
                ocount <= ocount + 16'd1;
            end
            if (drop)
                ooverflow <= 1'b1;
            occ <= occ_nxt;
        end
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (occ_nxt != 2'd0) state_nxt = ST_STREAM;
            ST_STREAM: if (final_xfer && occ_nxt == 2'd0) state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        owvalid = (state == ST_STREAM);
        owdata  = '0;
        owlast  = 1'b0;
        if (owvalid) begin
            owdata = slot[rd_ptr][word_idx];
            owlast = (word_idx == LAST_IDX);
        end
    end

endmodule
